// File: rtl/irq_timer.sv
// Memory-mapped programmable down-counter that raises irq when it reaches zero.
// Three word registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only).
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  logic [1:0]  state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = we && (addr == A_CTRL);
  assign preset_wr = we && (addr == A_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // PRESET of 0 lands here too, so it behaves like PRESET of 1
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode == 2'd1) irq_flag <= 1'b0;
          else              en       <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (preset_wr) preset <= din;

      // A CTRL write overrides the one-shot EN clear and acknowledges the interrupt
      if (ctrl_wr) begin
        en       <= din[0];
        mode     <= din[2:1];
        im       <= din[3];
        irq_flag <= 1'b0;
      end
    end
  end

  assign irq = irq_flag & im;

  always_comb begin
    dout = 32'd0;
    case (addr)
      A_CTRL:   dout = {28'd0, im, mode, en};
      A_PRESET: dout = preset;
      A_COUNT:  dout = count;
      default:  dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: a vector table for the one-shot walk-through and
// hand-written sequences for periodic, masking, pause, reset and collision cases.
module tb_irq_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int errors = 0;
  int checks = 0;

  irq_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    rd({tag, "_ctrl"},   2'd0, 32'd0);
    rd({tag, "_preset"}, 2'd1, 32'd0);
    rd({tag, "_count"},  2'd2, 32'd0);
    chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 32'hFFFF_FFF0, 2'd0, 32'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 32'd3,         2'd1, 32'd3, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 32'd55,        2'd2, 32'd0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 32'd77,        2'd3, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 32'h9,         2'd0, 32'h9, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd3, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd2, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd1, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 32'd0,         2'd2, 32'd0, 1'b1};
    vecs[10] = '{1'b0, 2'd0, 32'd0,         2'd0, 32'h8, 1'b1};
    vecs[11] = '{1'b0, 2'd0, 32'd0,         2'd1, 32'd3, 1'b1};

    do_reset();
    chk_all_zero("por");

    // one-shot walk-through from the table
    for (int i = 0; i < 12; i++) begin
      addr = vecs[i].waddr;
      din  = vecs[i].wdata;
      we   = vecs[i].we;
      tick();
      we   = 1'b0;
      addr = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("oneshot_hold%0d", c), {31'd0, irq}, 32'd1);
    end
    wr(2'd0, 32'd0);
    chk("oneshot_ack_irq", {31'd0, irq}, 32'd0);
    rd("oneshot_ack_ctrl", 2'd0, 32'd0);

    // reset while irq is high
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int c = 0; c < 3; c++) tick();
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_irq");
    tick();
    reset = 1'b0;

    // reset mid-count with COUNT=5
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    for (int c = 0; c < 5; c++) tick();
    rd("pre_reset_count", 2'd2, 32'd5);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    tick();
    reset = 1'b0;

    // periodic: P=2 -> period 5, first pulse 4 edges after the enabling write
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int c = 1; c <= 22; c++) begin
      tick();
      chk($sformatf("periodic_c%0d", c), {31'd0, irq},
          {31'd0, (c >= 4) && (((c - 4) % 5) == 0)});
    end
    rd("periodic_ctrl", 2'd0, 32'hB);

    // masked one-shot: flag sets but irq stays low
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("masked_c%0d", c), {31'd0, irq}, 32'd0);
    end
    rd("masked_count", 2'd2, 32'd0);
    rd("masked_ctrl", 2'd0, 32'd0);

    // pause: clear EN while counting, COUNT freezes, re-enable reloads
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    rd("pause_pre", 2'd2, 32'd3);
    wr(2'd0, 32'h8);
    for (int c = 0; c < 4; c++) tick();
    rd("pause_frozen", 2'd2, 32'd2);
    chk("pause_irq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd("pause_reload", 2'd2, 32'd4);

    // PRESET 0 and PRESET 1 both fire 3 edges after enable
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(2'd1, p);
      wr(2'd0, 32'h9);
      for (int c = 1; c <= 3; c++) begin
        tick();
        chk($sformatf("preset%0d_c%0d", p, c), {31'd0, irq}, {31'd0, c == 3});
      end
    end

    // PRESET write during CNT does not disturb the countdown
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick();
    tick();
    wr(2'd1, 32'd9);
    rd("midcnt_count", 2'd2, 32'd4);
    rd("midcnt_preset", 2'd1, 32'd9);
    for (int c = 4; c <= 7; c++) begin
      tick();
      chk($sformatf("midcnt_irq_c%0d", c), {31'd0, irq}, {31'd0, c == 7});
    end

    // CTRL write colliding with the one-shot INT step
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    chk("collide_pre_irq", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'hD);
    rd("collide_ctrl", 2'd0, 32'hD);
    chk("collide_irq", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped programmable down-counter that raises a hardware interrupt line to the CPU. Sits behind the system bridge on the data-memory bus. Its `irq` output drives `HWInt[0]` of the coprocessor-0 block, which samples `HWInt` into `Cause.IP` every cycle. Software programs it through three word registers using `sw`/`lw` issued in the M stage.

## Interface
- No parameters.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high; clock `clk`.
- `addr  in  2`: word offset within the timer window, byte address bits [3:2].
  - 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we  in  1`: write strobe, already gated by the bridge's address decode; sampled on `posedge clk`.
- `din  in  32`: write data.
- `dout  out  32`: read data, combinational from `addr`.
- `irq  out  1`: interrupt request, registered; equals `irq_flag & CTRL.IM`.

## Operation
- **CTRL register**
  - Writable bits: [0] EN, [2:1] MODE, [3] IM.
  - Bits [31:4] are not stored and read as 0.
  - MODE 0 = one-shot; MODE 1 = periodic; MODE 2 and 3 behave as MODE 0.
- **PRESET** is 32-bit read/write. A new value takes effect at the next LOAD state and never alters a count in progress.
- **COUNT** is 32-bit and read-only. Writes to COUNT and to offset 3 are ignored. Reads of offset 3 return 0.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: go to IDLE; COUNT holds its value (pause/abort).
  - CNT, EN=1, COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1, COUNT<=1: COUNT <= 0; irq_flag <= 1; go to INT.
  - INT, MODE 1: irq_flag <= 0; go to IDLE. EN is still 1, so the timer reloads automatically.
  - INT, MODE 0: EN <= 0; go to IDLE. irq_flag stays set.
- **irq_flag clear:** cleared by reset, by any CPU write to CTRL, or by the MODE 1 INT step.
- **Simultaneous events**
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the written value wins and irq_flag is cleared.
  - A CPU write in the same cycle as the LOAD state: LOAD uses the PRESET value from before the write.
- **PRESET = 0** behaves exactly like PRESET = 1.

## Timing
- **Reset values:** CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0. `dout` at addr 0 reads 0.
- **Start-up sequence** (CTRL write with EN=1 at edge E, then FSM state after each edge):
  - E+1: LOAD.
  - E+2: CNT, COUNT=P.
  - E+2+k: COUNT=P-k, for k < P.
  - E+1+P: COUNT=1.
  - E+2+P: INT, COUNT=0, irq=1 (if IM=1).
- **MODE 0:** `irq` stays high from E+2+P until the next CTRL write. EN reads 0 from E+3+P.
- **MODE 1:** `irq` is high for exactly one cycle, E+2+P to E+3+P.
  - Next sequence: IDLE at E+3+P, LOAD at E+4+P.
  - Interrupt period is P+3 cycles.
- **Interrupt mask:** IM=0 masks `irq` but not irq_flag. Setting IM=1 later while irq_flag=1 raises `irq` on the edge that writes CTRL… except that a CTRL write clears irq_flag, so a pending one-shot interrupt is lost. This is intended: software acknowledges by rewriting CTRL.
- **Reset mid-count:** every register returns to its reset value at that edge, and `irq` drops the same edge.
- **Reads:** `dout` reflects register state after the most recent edge; a write is visible on reads in the following cycle.

## Test plan
- **Reset:** assert reset for 2 cycles with prior COUNT=5 and irq=1 -> all registers read 0 and irq=0 on the cycle after the reset edge.
- **One-shot:** PRESET=3, then CTRL=0x9 (EN, MODE 0, IM) at edge E -> COUNT reads 3, 2, 1 at E+2..E+4. irq=1 from E+5 and held for 20 cycles. CTRL reads 0x8. Writing CTRL=0 drops irq the next edge.
- **Periodic:** PRESET=2, CTRL=0xB -> irq pulses 1 cycle wide, period 5 cycles, over 4 periods. CTRL stays 0xB.
- **Masked and pause:**
  - CTRL=0x1, PRESET=4 -> irq never rises; COUNT reaches 0.
  - Rerun with CTRL=0x9, then write CTRL=0x8 when COUNT=2 -> COUNT frozen at 2, no irq. Write CTRL=0x9 -> reloads 4.
- **Edge values and collisions:**
  - PRESET=0 -> irq 3 cycles after enable, same as PRESET=1.
  - A PRESET write during CNT does not change the current countdown.
  - A CTRL write coinciding with INT in MODE 0 leaves exactly the written CTRL value.
